// File: rtl/mobius_pkg.sv
// Shared definitions for the folded GF(2) Mobius transform engine.
//   mobius_state_e : control FSM state encoding (IDLE, RUN, DONE)
//   mobius_ref()   : full unrolled transform of a default-width vector,
//                    intended as a reference model for the bench
package mobius_pkg;

    localparam int MOBIUS_N_DEF      = 16;
    localparam int MOBIUS_LOG2_N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mobius_state_e;

    // In-place update is safe: the lower half of each block is never written
    // within a stage, so r[i - half] still holds the stage input.
    function automatic logic [0:MOBIUS_N_DEF-1] mobius_ref(input logic [0:MOBIUS_N_DEF-1] v);
        logic [0:MOBIUS_N_DEF-1] r;
        int half;
        r = v;
        for (int s = 0; s < MOBIUS_LOG2_N_DEF; s++) begin
            half = MOBIUS_N_DEF >> (s + 1);
            for (int i = 0; i < MOBIUS_N_DEF; i++) begin
                if ((i & half) != 0) r[i] = r[i] ^ r[i - half];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mobius_stage_sel.sv
// One butterfly stage of the GF(2) Mobius transform, stage chosen at runtime.
//   vec    : input vector, index 0 is the MSB
//   stage  : stage number s; half-distance is N >> (s+1)
//   result : vec with the upper half of every 2*half block XORed with its lower half
module mobius_stage_sel
    import mobius_pkg::*;
#(
    parameter int N      = 16,
    parameter int log2_N = 4
) (
    input  logic [0:N-1]                              vec,
    input  logic [((log2_N > 1) ? log2_N : 1)-1:0]    stage,
    output logic [0:N-1]                              result
);

    localparam int SW = (log2_N > 1) ? log2_N : 1;

    // An element sits in the upper half of its block exactly when the bit
    // of its index worth 'half' is set.
    always_comb begin
        result = vec;
        for (int s = 0; s < log2_N; s++) begin
            if (stage == SW'(s)) begin
                for (int i = 0; i < N; i++) begin
                    if (((i >> (log2_N - 1 - s)) & 1) == 1) begin
                        result[i] = vec[i] ^ vec[i - (N >> (s + 1))];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mobius_seq.sv
// Folded iterative Mobius transform over GF(2) with valid/ready streaming.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_data/valid/ready  : input vector handshake
//   out_data/valid/ready : result handshake; out_data held while out_valid
//   busy                 : high while stages are being applied
//   stage_idx            : next stage to apply, 0 outside RUN
//
// state | meaning
// IDLE  | waiting for an input vector
// RUN   | applying STAGES_PER_CYCLE stages per clock to the working register
// DONE  | result presented; may accept the next vector on the result handshake
module mobius_seq
    import mobius_pkg::*;
#(
    parameter int N                = 16,
    parameter int log2_N           = 4,
    parameter int STAGES_PER_CYCLE = 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [0:N-1]                           in_data,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    output logic [0:N-1]                           out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   busy,
    output logic [((log2_N > 1) ? log2_N : 1)-1:0] stage_idx
);

    localparam int SW = (log2_N > 1) ? log2_N : 1;

    if (N != (1 << log2_N) || STAGES_PER_CYCLE < 1 || (log2_N % STAGES_PER_CYCLE) != 0) begin : g_bad_params
        $error("mobius_seq: illegal N/log2_N/STAGES_PER_CYCLE combination");
    end

    mobius_state_e state;
    logic [0:N-1]  work;
    logic [0:N-1]  chain [0:STAGES_PER_CYCLE];
    logic          last_step;

    assign chain[0] = work;

    for (genvar k = 0; k < STAGES_PER_CYCLE; k++) begin : g_chain
        mobius_stage_sel #(
            .N      (N),
            .log2_N (log2_N)
        ) u_stage (
            .vec    (chain[k]),
            .stage  (stage_idx + SW'(k)),
            .result (chain[k+1])
        );
    end

    assign last_step = (stage_idx == SW'(log2_N - STAGES_PER_CYCLE));
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign out_data  = work;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            stage_idx <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work      <= in_data;
                        stage_idx <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    work <= chain[STAGES_PER_CYCLE];
                    if (last_step) begin
                        stage_idx <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        stage_idx <= stage_idx + SW'(STAGES_PER_CYCLE);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            work      <= in_data;
                            stage_idx <= '0;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    stage_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mobius_seq.sv
// Directed and randomised bench for mobius_seq (N=16).
// SPC selects STAGES_PER_CYCLE; expected latency is 4/SPC cycles.
module tb_mobius_seq
    import mobius_pkg::*;
#(
    parameter int SPC = 1
);

    localparam int LAT = 4 / SPC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:15] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [0:15] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic [3:0]  stage_idx;

    int checks   = 0;
    int failures = 0;

    mobius_seq #(
        .N                (16),
        .log2_N           (4),
        .STAGES_PER_CYCLE (SPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .stage_idx (stage_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one vector through and collect the result; lat = -1 on timeout.
    task automatic xfer(input logic [0:15] d, output logic [0:15] r, output int lat);
        int n;
        n = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
        r = out_data;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || stage_idx !== 4'd0 || out_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b stage_idx=%0d out_data=%h, required 1 0 0 0 0000",
                     in_ready, out_valid, busy, stage_idx, out_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_unit_vector();
        int cyc, busy_cyc;
        in_data  = 16'h8000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cyc = 0;
        busy_cyc = 0;
        while (!out_valid && cyc < 20) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== LAT) begin
            failures++;
            $display("FAIL unit_latency: got %0d cycles, required %0d", cyc, LAT);
        end
        checks++;
        if (busy_cyc !== LAT) begin
            failures++;
            $display("FAIL unit_busy: busy for %0d cycles, required %0d", busy_cyc, LAT);
        end
        checks++;
        if (out_data !== 16'hFFFF || busy !== 1'b0) begin
            failures++;
            $display("FAIL unit_data: out_data=%h busy=%b, required ffff 0", out_data, busy);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL unit_drain: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_all_ones();
        logic [0:15] r;
        int lat;
        xfer(16'hFFFF, r, lat);
        checks++;
        if (r !== 16'h8000 || lat !== LAT) begin
            failures++;
            $display("FAIL all_ones: out=%h lat=%0d, required 8000 %0d", r, lat, LAT);
        end
        xfer(16'h00FF, r, lat);
        checks++;
        if (r !== 16'h0080 || lat !== LAT) begin
            failures++;
            $display("FAIL low_byte: out=%h lat=%0d, required 0080 %0d", r, lat, LAT);
        end
        xfer(16'h0001, r, lat);
        checks++;
        if (r !== 16'h0001) begin
            failures++;
            $display("FAIL last_bit: out=%h, required 0001", r);
        end
    endtask

    task automatic test_backpressure();
        int n;
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_data = 16'h1234;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h8000 || in_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold[%0d]: out_valid=%b out_data=%h in_ready=%b busy=%b, required 1 8000 0 0",
                         c, out_valid, out_data, in_ready, busy);
            end
            tick();
        end
        in_data   = 16'h8000;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_follow: in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_handoff: busy=%b out_valid=%b, required 1 0", busy, out_valid);
        end
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== LAT || out_data !== 16'hFFFF) begin
            failures++;
            $display("FAIL bp_next: cycles=%0d out_data=%h, required %0d ffff", n, out_data, LAT);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [0:15] r;
        int lat, n;
        in_data  = 16'h00FF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (busy && stage_idx != 4'd2 && n < 4) begin
            tick();
            n++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || stage_idx !== 4'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b busy=%b stage_idx=%0d in_ready=%b, required 0 0 0 1",
                     out_valid, busy, stage_idx, in_ready);
        end
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_discard: out_valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        xfer(16'h8000, r, lat);
        checks++;
        if (r !== 16'hFFFF || lat !== LAT) begin
            failures++;
            $display("FAIL mid_reset_next: out=%h lat=%0d, required ffff %0d", r, lat, LAT);
        end
    endtask

    task automatic test_involution();
        logic [0:15] v, r1, r2;
        int lat1, lat2;
        for (int k = 0; k < 20; k++) begin
            v = 16'($urandom);
            xfer(v, r1, lat1);
            xfer(r1, r2, lat2);
            checks++;
            if (r2 !== v || lat1 !== LAT || lat2 !== LAT) begin
                failures++;
                $display("FAIL involution[%0d]: back=%h lat=%0d/%0d, required %h %0d", k, r2, lat1, lat2, v, LAT);
            end
        end
    endtask

    task automatic test_random_stream();
        logic [0:15] q[$];
        logic [0:15] exp;
        logic in_fire, out_fire;
        int sent, recv, cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 1000 && cyc < 40000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_spurious: unexpected out_data=%h", out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp) begin
                        failures++;
                        $display("FAIL stream[%0d]: out_data=%h, required %h", recv, out_data, exp);
                    end
                end
                recv++;
            end
            if (in_fire) begin
                q.push_back(mobius_ref(in_data));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (recv !== 1000) begin
            failures++;
            $display("FAIL stream_count: received %0d, required 1000", recv);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_unit_vector();
        test_all_ones();
        test_backpressure();
        test_reset_mid_run();
        test_involution();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
